reg_axi_master: RTL and testbench
=================================

Name: reg_axi_master

Overview:
- Reverse direction of the team's AXI-Lite-to-register slave: accepts a single-beat register access request on a simple local interface and issues it as one AXI4-Lite master transaction.
- Sits between local control logic (e.g. the QSFP I2C sequencer or a bring-up FSM) and an AXI-Lite interconnect or peripheral.
- One outstanding transaction at a time; completion is reported with a done pulse, read data and response code.

Parameters:
- AXI_ADDR_WIDTH, 32, address width of the AXI and local buses.
- AXI_DATA_WIDTH, 32, data width; must be 32 or 64.
- TIMEOUT_CYCLES, 1024, watchdog limit in clocks; used only with the optional feature.

Ports:
- m_axi_aclk  in  1  clock.
- m_axi_areset  in  1  reset, asynchronous, active-high.
- req  in  1  start request; sampled only while busy=0.
- req_wr  in  1  1=write, 0=read; sampled with req.
- req_addr  in  AXI_ADDR_WIDTH  access address.
- req_wdata  in  AXI_DATA_WIDTH  write data.
- req_wstrb  in  AXI_DATA_WIDTH/8  write strobes.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle completion pulse.
- resp  out  2  BRESP or RRESP of the last transaction; 2'b11 on timeout.
- rd_data  out  AXI_DATA_WIDTH  last read data.
- m_axi_awaddr/awvalid/awready: out AXI_ADDR_WIDTH / out 1 / in 1.
- m_axi_wdata/wstrb/wvalid/wready: out AXI_DATA_WIDTH / out AXI_DATA_WIDTH/8 / out 1 / in 1.
- m_axi_bresp/bvalid/bready: in 2 / in 1 / out 1.
- m_axi_araddr/arvalid/arready: out AXI_ADDR_WIDTH / out 1 / in 1.
- m_axi_rdata/rresp/rvalid/rready: in AXI_DATA_WIDTH / in 2 / in 1 / out 1.

Behaviour:
Reset and outputs:
- Every output is registered.
- Reset values: all valid/ready outputs, busy, done, resp and rd_data are 0; addr, data and strobe outputs are 0.
- Reset takes effect asynchronously, including mid-transaction. Valids drop immediately and the FSM returns to IDLE with no done pulse.

State machine (IDLE, WR, WR_RESP, RD_ADDR, RD_DATA):
- IDLE: on req=1, latch addr/wdata/wstrb and set busy=1 the next cycle.
  - If req_wr=1, go to WR and assert awvalid and wvalid together one cycle after req.
  - If req_wr=0, go to RD_ADDR and assert arvalid one cycle after req.
- WR: awvalid and wvalid are tracked independently.
  - Each is held with stable payload until its own ready is sampled high, then deasserted the next cycle.
  - AW and W may complete in either order or in the same cycle.
  - Go to WR_RESP once both have completed.
- WR_RESP: bready=1. On bvalid&&bready, capture bresp into resp, pulse done, clear bready and busy, and return to IDLE.
  - Total minimum latency is 3 clocks from req to done when all readies are already high.
- RD_ADDR: arvalid is held until arready. Then go to RD_DATA with rready=1.
- RD_DATA: on rvalid&&rready, capture rdata into rd_data and rresp into resp, pulse done, clear busy, and return to IDLE.

Boundary and other rules:
- done and busy fall in the same cycle.
- A new req is accepted in the cycle after done (back-to-back).
- req while busy=1 is ignored and never queued.
- bvalid or rvalid arriving before the address handshake completes is not accepted: bready and rready are 0 outside their states.
- rd_data and resp hold their values until the next completion.
- A write does not modify rd_data.

Optional Feature:
- Macro: REG_AXI_MASTER_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on request acceptance and increments every busy cycle.
  - If it reaches TIMEOUT_CYCLES before completion, all valid/ready outputs drop, done pulses, resp=2'b11, rd_data=0, and the FSM returns to IDLE.
  - Completion in the same cycle as expiry takes priority over the timeout.
- Without the macro: no counter; the block waits indefinitely and TIMEOUT_CYCLES is unused.

Test Plan:
- Write addr=0x10, data=0xA5A5_0001, wstrb=0xF, all readies tied high, bresp=0 -> awvalid/wvalid high exactly one cycle with the correct payload; done 3 clocks after req; resp=0.
- Write with awready delayed 4 cycles and wready immediate -> wvalid drops after 1 cycle; awvalid holds a stable address for 5 cycles; a single done pulse follows the B handshake.
- Read addr=0x20, arready delayed 2 cycles, rdata=0x1234_5678, rresp=2'b10 -> rd_data=0x1234_5678 and resp=2'b10 on done; rd_data unchanged by a following write.
- req pulsed while busy, then back-to-back req in the cycle after done -> the first extra req is ignored; the second starts a new transaction the next cycle.
- Assert m_axi_areset mid-write with awvalid high -> awvalid, wvalid and busy go to 0 immediately with no done; a new read after reset completes normally.
- With REG_AXI_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, never assert bvalid -> done is seen 16 cycles after acceptance with resp=2'b11, and bready returns to 0.

Source files
------------

// File: rtl/reg_axi_master.sv
// reg_axi_master: turns one local register access request into a single
// AXI4-Lite master transaction (write: AW+W then B, read: AR then R).
// Only one transaction is in flight at a time. Completion is reported with a
// one-cycle done pulse, the captured response code and the last read data.
//
// Ports:
//   m_axi_aclk, m_axi_areset  clock, asynchronous active-high reset
//   req/req_wr/req_addr/req_wdata/req_wstrb  local request (sampled when !busy)
//   busy, done, resp, rd_data                local status / completion
//   m_axi_aw*, m_axi_w*, m_axi_b*, m_axi_ar*, m_axi_r*  AXI4-Lite master
//
// Optional feature: define REG_AXI_MASTER_TIMEOUT_EN to enable a watchdog that
// aborts a transaction after TIMEOUT_CYCLES busy clocks with resp=2'b11.
module reg_axi_master #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                        m_axi_aclk,
  input  logic                        m_axi_areset,
  // local request side
  input  logic                        req,
  input  logic                        req_wr,
  input  logic [AXI_ADDR_WIDTH-1:0]   req_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   req_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] req_wstrb,
  output logic                        busy,
  output logic                        done,
  output logic [1:0]                  resp,
  output logic [AXI_DATA_WIDTH-1:0]   rd_data,
  // write address channel
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  // write data channel
  output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  // write response channel
  input  logic [1:0]                  m_axi_bresp,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  // read address channel
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  // read data channel
  input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready
);

  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_ADDR = 3'd3,
    S_RD_DATA = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [1:0]                resp_q, resp_d;
  logic [AXI_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]         wstrb_q, wstrb_d;
  logic                      awvalid_q, awvalid_d;
  logic                      wvalid_q, wvalid_d;
  logic                      bready_q, bready_d;
  logic                      arvalid_q, arvalid_d;
  logic                      rready_q, rready_d;

`ifdef REG_AXI_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    resp_d    = resp_q;
    rd_data_d = rd_data_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          busy_d  = 1'b1;
          if (req_wr) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = S_RD_ADDR;
          end
        end
      end
      S_WR: begin
        // AW and W retire independently; a low valid means that channel is done
        if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (bready_q && m_axi_bvalid) begin
          resp_d   = m_axi_bresp;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          bready_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      S_RD_ADDR: begin
        if (arvalid_q && m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (rready_q && m_axi_rvalid) begin
          rd_data_d = m_axi_rdata;
          resp_d    = m_axi_rresp;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          rready_d  = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef REG_AXI_MASTER_TIMEOUT_EN
    // Watchdog: fires on the busy clock that would bring the count to the
    // limit; a normal completion in that same clock wins.
    cnt_d = '0;
    if (busy_q) begin
      cnt_d = cnt_q + CNT_W'(1);
      if ((cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) && !done_d) begin
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        resp_d    = 2'b11;
        rd_data_d = '0;
        state_d   = S_IDLE;
        cnt_d     = '0;
      end
    end
`endif
  end

  // State and output registers
  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      resp_q    <= 2'b00;
      rd_data_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
`ifdef REG_AXI_MASTER_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      resp_q    <= resp_d;
      rd_data_q <= rd_data_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
`ifdef REG_AXI_MASTER_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign resp          = resp_q;
  assign rd_data       = rd_data_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_reg_axi_master.sv
// tb_reg_axi_master: table-driven bench for reg_axi_master with a small
// AXI-Lite slave model (programmable ready/response delays) and a scoreboard
// of expected completions (resp, rd_data, latency from req to done).
module tb_reg_axi_master;

  logic        clk = 1'b0;
  logic        areset;
  logic        req, req_wr;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        busy, done;
  logic [1:0]  resp;
  logic [31:0] rd_data;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready, arvalid, arready, rvalid, rready;

  always #5 clk = ~clk;

  reg_axi_master #(
    .AXI_ADDR_WIDTH(32),
    .AXI_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .m_axi_aclk(clk), .m_axi_areset(areset),
    .req(req), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .busy(busy), .done(done), .resp(resp), .rd_data(rd_data),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  // d1: aw/ar ready delay, d2: w ready delay, d3: b/r valid delay
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          d1, d2, d3;
    logic [1:0]  rsp;
    logic [31:0] rdat;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] rd;
    int          lat;
    int          cyc;
  } sb_t;

  sb_t  sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  // slave configuration for the transaction in flight
  logic [31:0] cfg_addr, cfg_wdata, cfg_rdat;
  logic [3:0]  cfg_wstrb;
  logic [1:0]  cfg_rsp;
  int          cfg_d1, cfg_d2, cfg_d3;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // AXI-Lite slave model, driven away from the active edge
  bit aw_seen, w_seen, ar_seen;
  int aw_wait, w_wait, b_wait, ar_wait, r_wait;

  initial begin
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rresp = 0; rdata = 0;
    aw_seen = 0; w_seen = 0; ar_seen = 0;
    aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
  end

  always @(negedge clk) begin
    if (areset || done) begin
      awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
      aw_seen = 0; w_seen = 0; ar_seen = 0;
      aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
    end else begin
      if (!(aw_seen && w_seen)) chk("bready_early", bready, 0);
      if (!ar_seen) chk("rready_early", rready, 0);
      if (awvalid) begin
        chk("aw_payload", awaddr, cfg_addr);
        chk("aw_held_after_hs", aw_seen, 0);
        if (aw_wait == cfg_d1) begin awready = 1; aw_seen = 1; end
        else begin awready = 0; aw_wait++; end
      end else awready = 0;
      if (wvalid) begin
        chk("w_payload", {wstrb, wdata}, {cfg_wstrb, cfg_wdata});
        chk("w_held_after_hs", w_seen, 0);
        if (w_wait == cfg_d2) begin wready = 1; w_seen = 1; end
        else begin wready = 0; w_wait++; end
      end else wready = 0;
      if (aw_seen && w_seen && !bvalid) begin
        if (b_wait == cfg_d3) begin bvalid = 1; bresp = cfg_rsp; end
        else b_wait++;
      end
      if (arvalid) begin
        chk("ar_payload", araddr, cfg_addr);
        chk("ar_held_after_hs", ar_seen, 0);
        if (ar_wait == cfg_d1) begin arready = 1; ar_seen = 1; end
        else begin arready = 0; ar_wait++; end
      end else arready = 0;
      if (ar_seen && !rvalid) begin
        if (r_wait == cfg_d3) begin rvalid = 1; rdata = cfg_rdat; rresp = cfg_rsp; end
        else r_wait++;
      end
    end
  end

  // Completion monitor: pops the scoreboard on every done pulse
  always @(negedge clk) begin
    if (!areset && done) begin
      if (sb_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_done: got done=1, expected no completion (cycle %0d)", cyc);
      end else begin
        sb_t it;
        it = sb_q.pop_front();
        chk("resp", resp, it.resp);
        chk("rd_data", rd_data, it.rd);
        chk("busy_with_done", busy, 0);
        if (it.lat != 0) chk("latency", cyc - it.cyc, it.lat);
      end
    end
  end

  // Drive one request for one cycle and record its expected completion
  task automatic issue(input vec_t v);
    sb_t it;
    cfg_addr = v.addr; cfg_wdata = v.wdata; cfg_wstrb = v.wstrb;
    cfg_d1 = v.d1; cfg_d2 = v.d2; cfg_d3 = v.d3;
    cfg_rsp = v.rsp; cfg_rdat = v.rdat;
    it.resp = v.exp_resp; it.rd = v.exp_rd; it.lat = v.exp_lat; it.cyc = cyc;
    sb_q.push_back(it);
    req = 1; req_wr = v.wr; req_addr = v.addr; req_wdata = v.wdata; req_wstrb = v.wstrb;
    @(negedge clk);
    req = 0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      if (done) seen = 1;
      else @(negedge clk);
    end
    if (!seen) begin
      n_vec++; n_err++;
      $display("FAIL wait_done: got no done, expected one within %0d cycles", budget);
    end
  endtask

  vec_t vecs[7];
  vec_t hv;

  initial begin
    //          wr    addr      wdata         strb  d1 d2 d3  rsp  rdat          eresp  erd           lat
    vecs[0] = '{1'b1, 32'h10, 32'hA5A5_0001, 4'hF, 0, 0, 0, 2'd0, 32'h0,         2'd0, 32'h0,         3};
    vecs[1] = '{1'b1, 32'h14, 32'hDEAD_BEEF, 4'h3, 4, 0, 0, 2'd0, 32'h0,         2'd0, 32'h0,         7};
    vecs[2] = '{1'b0, 32'h20, 32'h0,         4'h0, 2, 0, 0, 2'd2, 32'h1234_5678, 2'd2, 32'h1234_5678, 5};
    vecs[3] = '{1'b1, 32'h24, 32'h1111_2222, 4'hC, 0, 3, 2, 2'd1, 32'h0,         2'd1, 32'h1234_5678, 7};
    vecs[4] = '{1'b0, 32'h28, 32'h0,         4'h0, 0, 0, 3, 2'd0, 32'hCAFE_F00D, 2'd0, 32'hCAFE_F00D, 5};
    vecs[5] = '{1'b1, 32'h2C, 32'h55AA_55AA, 4'hF, 2, 2, 0, 2'd3, 32'h0,         2'd3, 32'hCAFE_F00D, 5};
    vecs[6] = '{1'b0, 32'h30, 32'h0,         4'h0, 0, 0, 0, 2'd0, 32'h0,         2'd0, 32'h0,         3};

    areset = 1; req = 0; req_wr = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
    cfg_addr = 0; cfg_wdata = 0; cfg_wstrb = 0; cfg_rsp = 0; cfg_rdat = 0;
    cfg_d1 = 0; cfg_d2 = 0; cfg_d3 = 0;
    repeat (3) @(negedge clk);
    chk("rst_status", {busy, done, resp}, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
    chk("rst_payload", {awaddr, araddr}, 0);
    chk("rst_wpayload", {wstrb, wdata}, 0);
    areset = 0;
    @(negedge clk);

    // table: back-to-back transactions, each issued in its predecessor's done cycle
    for (int i = 0; i < 7; i++) begin
      issue(vecs[i]);
      wait_done(200);
    end

    // extra req while busy is dropped; next req in the done cycle starts at once
    hv = '{1'b1, 32'h40, 32'h0BAD_F00D, 4'hF, 4, 0, 0, 2'd0, 32'h0, 2'd0, 32'h0, 7};
    issue(hv);
    req = 1; req_wr = 0; req_addr = 32'h99;
    @(negedge clk);
    req = 0;
    @(negedge clk);
    chk("busy_req_ignored", {busy, arvalid}, 2'b10);
    wait_done(200);
    hv = '{1'b0, 32'h44, 32'h0, 4'h0, 1, 0, 0, 2'd0, 32'h8765_4321, 2'd0, 32'h8765_4321, 4};
    issue(hv);
    chk("b2b_started", {busy, arvalid}, 2'b11);
    wait_done(200);

    // asynchronous reset in the middle of a write
    hv = '{1'b1, 32'h48, 32'h7777_8888, 4'hF, 10, 0, 0, 2'd0, 32'h0, 2'd0, 32'h0, 0};
    issue(hv);
    chk("aw_pending", awvalid, 1);
    areset = 1;
    #1;
    chk("rst_async_valids", {awvalid, wvalid, busy}, 0);
    chk("rst_async_done", done, 0);
    sb_q.delete();
    @(negedge clk);
    areset = 0;
    @(negedge clk);
    chk("post_rst_idle", {busy, done}, 0);
    hv = '{1'b0, 32'h50, 32'h0, 4'h0, 0, 0, 0, 2'd1, 32'hFEED_FACE, 2'd1, 32'hFEED_FACE, 3};
    issue(hv);
    wait_done(200);

`ifdef REG_AXI_MASTER_TIMEOUT_EN
    // no B response: watchdog completes 16 busy clocks after acceptance
    hv = '{1'b1, 32'h60, 32'h1, 4'hF, 0, 0, 1000, 2'd0, 32'h0, 2'd3, 32'h0, 17};
    issue(hv);
    wait_done(200);
    chk("timeout_bready", bready, 0);
    @(negedge clk);
    chk("timeout_idle", {busy, bready}, 0);
`else
    // no B response: the master keeps waiting with bready high
    hv = '{1'b1, 32'h60, 32'h1, 4'hF, 0, 0, 1000, 2'd0, 32'h0, 2'd0, 32'h0, 0};
    issue(hv);
    repeat (30) @(negedge clk);
    chk("no_timeout_wait", {busy, bready, done}, 3'b110);
    areset = 1;
    sb_q.delete();
    @(negedge clk);
    areset = 0;
    @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

endmodule
